// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if
//   Groups the arbiter's request/bus-observation inputs and its grant outputs.
//   The lock signals exist only when AHB_ARB_LOCK_EN is defined.
//
//   Modports:
//     slave  - the arbiter: observes requests and the muxed bus, drives grants
//     master - requesters / bus fabric: drive requests and bus status,
//              observe grants
//
//   Signals:
//     req_in          per-master bus request (level)
//     lock_in         per-master locked-sequence request (AHB_ARB_LOCK_EN)
//     ahb_trans_in    muxed HTRANS of the current owner
//     ahb_burst_in    muxed HBURST
//     ahb_ready_in    bus HREADY
//     ahb_resp_in     bus HRESP, 1 = ERROR
//     grant_out       one-hot grant
//     master_out      address-phase owner index
//     data_master_out data-phase owner index
//     mastlock_out    locked-transfer indication (AHB_ARB_LOCK_EN)
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] req_in;
`ifdef AHB_ARB_LOCK_EN
    logic [NUM_MASTERS-1:0] lock_in;
    logic                   mastlock_out;
`endif
    logic [1:0]             ahb_trans_in;
    logic [2:0]             ahb_burst_in;
    logic                   ahb_ready_in;
    logic                   ahb_resp_in;
    logic [NUM_MASTERS-1:0] grant_out;
    logic [MIDX_W-1:0]      master_out;
    logic [MIDX_W-1:0]      data_master_out;

`ifdef AHB_ARB_LOCK_EN
    modport slave (
        input  req_in, lock_in, ahb_trans_in, ahb_burst_in, ahb_ready_in, ahb_resp_in,
        output grant_out, master_out, data_master_out, mastlock_out
    );
    modport master (
        output req_in, lock_in, ahb_trans_in, ahb_burst_in, ahb_ready_in, ahb_resp_in,
        input  grant_out, master_out, data_master_out, mastlock_out
    );
`else
    modport slave (
        input  req_in, ahb_trans_in, ahb_burst_in, ahb_ready_in, ahb_resp_in,
        output grant_out, master_out, data_master_out
    );
    modport master (
        output req_in, ahb_trans_in, ahb_burst_in, ahb_ready_in, ahb_resp_in,
        input  grant_out, master_out, data_master_out
    );
`endif
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Round-robin, burst-aware AHB arbiter. Watches the muxed bus of the current
//   owner and only re-arbitrates at legal boundaries: idle/single transfers,
//   the last beat of a fixed-length burst, an early-terminating NONSEQ, an
//   ERROR response (second cycle, HREADY=1), or after INCR_MAX_BEATS beats of
//   an undefined-length INCR while someone else is requesting.
//
//   Optional feature macro: AHB_ARB_LOCK_EN (adds lock_in / mastlock_out;
//   a locked owner is re-granted at every re-arbitration point).
//
//   Ports:
//     ahb_clk_in   bus clock
//     ahb_rstn_in  asynchronous active-low reset
//     bus          ahb_arbiter_if.slave (requests, bus status, grant outputs)
//
//   state  | meaning
//   -------+----------------------------------------------
//   IDLE   | no burst open
//   BURST  | fixed-length burst, beats_left counts down
//   INCR   | undefined-length INCR, incr_cnt counts up
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int INCR_MAX_BEATS = 8,
    parameter int MIDX_W         = $clog2(NUM_MASTERS)
) (
    input logic          ahb_clk_in,
    input logic          ahb_rstn_in,
    ahb_arbiter_if.slave bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [MIDX_W-1:0]      DEF_IDX     = MIDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] GRANT_ONE   = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] GRANT_RST   = GRANT_ONE << DEF_IDX;
    localparam logic [7:0]             INCR_MAX    = 8'(INCR_MAX_BEATS);
    localparam logic [7:0]             INCR_PREEMPT = 8'(INCR_MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_INCR  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             beats_q, beats_d;
    logic [7:0]             incr_q, incr_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MIDX_W-1:0]      master_q, master_d;
    logic [MIDX_W-1:0]      data_master_q, data_master_d;

    logic              rp;
    logic              load;
    logic              other_req;
    logic              owner_locked;
    logic              found;
    logic [MIDX_W-1:0] idx;
    logic [MIDX_W-1:0] rr_winner;

`ifdef AHB_ARB_LOCK_EN
    logic mastlock_q, mastlock_d;
    assign owner_locked = bus.lock_in[master_q];
`else
    assign owner_locked = 1'b0;
`endif

    assign other_req = |(bus.req_in & ~grant_q);

    // Round-robin scan starting just after the current owner; the owner itself
    // is visited last, so it only wins again if nobody else is asking.
    always_comb begin
        rr_winner = DEF_IDX;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = MIDX_W'((int'(master_q) + k) % NUM_MASTERS);
            if (!found && bus.req_in[idx]) begin
                rr_winner = idx;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state_q       <= ST_IDLE;
            beats_q       <= '0;
            incr_q        <= '0;
            grant_q       <= GRANT_RST;
            master_q      <= DEF_IDX;
            data_master_q <= DEF_IDX;
`ifdef AHB_ARB_LOCK_EN
            mastlock_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            beats_q       <= beats_d;
            incr_q        <= incr_d;
            grant_q       <= grant_d;
            master_q      <= master_d;
            data_master_q <= data_master_d;
`ifdef AHB_ARB_LOCK_EN
            mastlock_q    <= mastlock_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        beats_d       = beats_q;
        incr_d        = incr_q;
        grant_d       = grant_q;
        master_d      = master_q;
        data_master_d = data_master_q;
        rp            = 1'b0;
        load          = 1'b0;

        if (bus.ahb_ready_in) begin
            if (bus.ahb_resp_in) begin
                rp = 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.ahb_trans_in == HTRANS_IDLE ||
                            (bus.ahb_trans_in == HTRANS_NONSEQ && bus.ahb_burst_in == HBURST_SINGLE))
                            rp = 1'b1;
                        else if (bus.ahb_trans_in == HTRANS_NONSEQ)
                            load = 1'b1;
                    end
                    ST_BURST: begin
                        if (bus.ahb_trans_in == HTRANS_SEQ && beats_q == 4'd1) begin
                            rp = 1'b1;
                        end else if (bus.ahb_trans_in == HTRANS_NONSEQ) begin
                            // early termination: arbitrate, then track the new burst
                            rp   = 1'b1;
                            load = 1'b1;
                        end else if (bus.ahb_trans_in == HTRANS_SEQ) begin
                            beats_d = beats_q - 4'd1;
                        end
                    end
                    ST_INCR: begin
                        if (bus.ahb_trans_in == HTRANS_IDLE || bus.ahb_trans_in == HTRANS_NONSEQ)
                            rp = 1'b1;
                        else if (bus.ahb_trans_in == HTRANS_SEQ && incr_q == INCR_PREEMPT && other_req)
                            rp = 1'b1;
                        else if (bus.ahb_trans_in == HTRANS_SEQ && incr_q != INCR_MAX)
                            incr_d = incr_q + 8'd1;
                    end
                    default: rp = 1'b1;
                endcase
            end
        end

        if (rp) begin
            state_d  = ST_IDLE;
            beats_d  = '0;
            incr_d   = '0;
            master_d = owner_locked ? master_q : rr_winner;
            grant_d  = GRANT_ONE << master_d;
        end

        if (load) begin
            unique case (bus.ahb_burst_in)
                HBURST_SINGLE: state_d = ST_IDLE;
                HBURST_INCR: begin
                    state_d = ST_INCR;
                    incr_d  = 8'd1;
                end
                HBURST_WRAP4, HBURST_INCR4: begin
                    state_d = ST_BURST;
                    beats_d = 4'd3;
                end
                HBURST_WRAP8, HBURST_INCR8: begin
                    state_d = ST_BURST;
                    beats_d = 4'd7;
                end
                HBURST_WRAP16, HBURST_INCR16: begin
                    state_d = ST_BURST;
                    beats_d = 4'd15;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // data phase follows the address phase by one accepted cycle
        if (bus.ahb_ready_in)
            data_master_d = master_q;
    end

`ifdef AHB_ARB_LOCK_EN
    always_comb begin
        mastlock_d = mastlock_q;
        if (bus.ahb_ready_in && bus.ahb_trans_in == HTRANS_NONSEQ)
            mastlock_d = owner_locked;
        else if (rp && !owner_locked)
            mastlock_d = 1'b0;
    end
    assign bus.mastlock_out = mastlock_q;
`endif

    assign bus.grant_out       = grant_q;
    assign bus.master_out      = master_q;
    assign bus.data_master_out = data_master_q;

endmodule
